// File: rtl/vec_lane_seq.sv
// rtl/vec_lane_seq.sv - shares one N-bit scalar ALU across the M lanes of a vector op,
// issuing one lane per cycle and assembling the M*N-bit result with combined flags.
module vec_lane_seq #(
  parameter int N = 24,
  parameter int M = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           start,
  input  logic           modeSel,
  input  logic [M*N-1:0] srcA,
  input  logic [M*N-1:0] srcB,
  input  logic [3:0]     aluControl,
  output logic [N-1:0]   aluA,
  output logic [N-1:0]   aluB,
  output logic [3:0]     aluCtl,
  output logic           aluValid,
  input  logic [N-1:0]   aluResult,
  input  logic [1:0]     aluFlags,
  output logic [M*N-1:0] result,
  output logic [1:0]     flagsOut,
  output logic           resultValid,
  output logic           stall,
  output logic           busy
);

  localparam int LW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [LW-1:0]  lane_q, lane_d;
  logic [LW-1:0]  last_q, last_d;
  logic [M*N-1:0] op_a_q, op_a_d;
  logic [M*N-1:0] op_b_q, op_b_d;
  logic [M*N-1:0] result_q, result_d;
  logic [3:0]     ctl_q, ctl_d;
  logic           zacc_q, zacc_d;
  logic           nacc_q, nacc_d;
  logic [1:0]     flags_q, flags_d;

  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    last_d   = last_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    ctl_d    = ctl_q;
    zacc_d   = zacc_q;
    nacc_d   = nacc_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_a_d   = srcA;
          op_b_d   = srcB;
          ctl_d    = aluControl;
          result_d = '0;
          lane_d   = '0;
          // A scalar op is simply a one-lane run, so upper lanes stay zero.
          last_d   = modeSel ? LW'(M - 1) : '0;
          zacc_d   = 1'b1;
          nacc_d   = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < M; i++) begin
          if (lane_q == LW'(i)) result_d[i*N +: N] = aluResult;
        end
        zacc_d = zacc_q & aluFlags[0];
        nacc_d = nacc_q | aluFlags[1];
        if (lane_q == last_q) begin
          flags_d = {nacc_d, zacc_d};
          state_d = DONE;
        end else begin
          lane_d = lane_q + LW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // en gates every register update, so en=0 freezes the whole sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      lane_q   <= '0;
      last_q   <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      ctl_q    <= '0;
      zacc_q   <= 1'b0;
      nacc_q   <= 1'b0;
      flags_q  <= '0;
    end else if (en) begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      last_q   <= last_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      ctl_q    <= ctl_d;
      zacc_q   <= zacc_d;
      nacc_q   <= nacc_d;
      flags_q  <= flags_d;
    end
  end

  always_comb begin
    aluA     = '0;
    aluB     = '0;
    aluCtl   = '0;
    aluValid = 1'b0;
    if (state_q == RUN) begin
      for (int i = 0; i < M; i++) begin
        if (lane_q == LW'(i)) begin
          aluA = op_a_q[i*N +: N];
          aluB = op_b_q[i*N +: N];
        end
      end
      aluCtl   = ctl_q;
      aluValid = en;
    end
  end

  assign stall       = (state_q == RUN) | ((state_q == IDLE) & start & en);
  assign resultValid = (state_q == DONE) & en;
  assign busy        = (state_q != IDLE);
  assign result      = result_q;
  assign flagsOut    = flags_q;

endmodule

// File: tb/tb_vec_lane_seq.sv
// tb/tb_vec_lane_seq.sv - directed vector table plus hand sequences for vec_lane_seq,
// with a behavioural add/sub ALU closing the loop on the shared ALU port.
module tb_vec_lane_seq;

  localparam int N = 24;
  localparam int M = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en = 1'b0;
  logic           start = 1'b0;
  logic           mode_sel = 1'b0;
  logic [M*N-1:0] src_a = '0;
  logic [M*N-1:0] src_b = '0;
  logic [3:0]     alu_control = '0;
  logic [N-1:0]   alu_a, alu_b, alu_result;
  logic [3:0]     alu_ctl;
  logic           alu_valid;
  logic [1:0]     alu_flags;
  logic [M*N-1:0] result;
  logic [1:0]     flags_out;
  logic           result_valid, stall, busy;

  int n_checks = 0;
  int n_fail   = 0;

  vec_lane_seq #(.N(N), .M(M)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .modeSel(mode_sel),
    .srcA(src_a), .srcB(src_b), .aluControl(alu_control),
    .aluA(alu_a), .aluB(alu_b), .aluCtl(alu_ctl), .aluValid(alu_valid),
    .aluResult(alu_result), .aluFlags(alu_flags),
    .result(result), .flagsOut(flags_out), .resultValid(result_valid),
    .stall(stall), .busy(busy)
  );

  always #5 clk = ~clk;

  // ctl 1 subtracts, anything else adds
  assign alu_result = (alu_ctl == 4'd1) ? alu_a - alu_b : alu_a + alu_b;
  assign alu_flags  = {alu_result[N-1], alu_result == '0};

  typedef struct {
    string          name;
    logic           mode;
    logic [3:0]     ctl;
    logic [M*N-1:0] a;
    logic [M*N-1:0] b;
    logic [M*N-1:0] res;
    logic [1:0]     flags;
    int             lat;
    int             stalls;
    int             valids;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [M*N-1:0] act, input logic [M*N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cycle 1 is the accept cycle; en is dropped for gap_len cycles starting at cycle gap_at.
  task automatic run_op(input vec_t v, input int gap_at, input int gap_len,
                        input int extra_lat, input int extra_stall);
    int lat = 0;
    int stalls = 0;
    int lanes = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start       = (c == 1);
      en          = !(c >= gap_at && c < gap_at + gap_len);
      mode_sel    = v.mode;
      alu_control = v.ctl;
      src_a       = (c == 1) ? v.a : ~v.a;
      src_b       = (c == 1) ? v.b : ~v.b;
      #1;
      if (c == 1) check({v.name, " accept_stall"}, stall, 1'b1);
      if (!en) check({v.name, " gap_alu_valid"}, alu_valid, 1'b0);
      if (alu_valid) begin
        check({v.name, " lane_a"}, alu_a, v.a[(lanes % M)*N +: N]);
        check({v.name, " lane_b"}, alu_b, v.b[(lanes % M)*N +: N]);
        check({v.name, " lane_ctl"}, alu_ctl, v.ctl);
        lanes++;
      end
      if (stall) stalls++;
      if (result_valid) begin
        lat = c;
        break;
      end
    end
    check({v.name, " latency"}, lat, v.lat + extra_lat);
    check({v.name, " stall_cycles"}, stalls, v.stalls + extra_stall);
    check({v.name, " alu_valid_count"}, lanes, v.valids);
    check({v.name, " result"}, result, v.res);
    check({v.name, " flags"}, flags_out, v.flags);
    @(negedge clk);
    start = 1'b0;
    en    = 1'b1;
    #1;
    check({v.name, " pulse_width"}, result_valid, 1'b0);
    check({v.name, " idle_after"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int pulses;
    vecs[0] = '{"scalar_add", 1'b0, 4'd0,
                {{5{24'hABCDEF}}, 24'd5}, {{5{24'h111111}}, 24'd7},
                {120'h0, 24'd12}, 2'b00, 3, 2, 1};
    vecs[1] = '{"vector_add", 1'b1, 4'd0,
                {24'd6, 24'd5, 24'd4, 24'd3, 24'd2, 24'd1}, {6{24'd10}},
                {24'd16, 24'd15, 24'd14, 24'd13, 24'd12, 24'd11}, 2'b00, 8, 7, 6};
    vecs[2] = '{"vector_sub_zero", 1'b1, 4'd1,
                {6{24'h000123}}, {6{24'h000123}},
                {M*N{1'b0}}, 2'b01, 8, 7, 6};
    vecs[3] = '{"vector_sub_neg", 1'b1, 4'd1,
                {24'h000123, 24'h000001, {4{24'h000123}}},
                {24'h000123, 24'h000002, {4{24'h000123}}},
                {24'h0, 24'hFFFFFF, 96'h0}, 2'b10, 8, 7, 6};
    vecs[4] = '{"scalar_sub", 1'b0, 4'd1,
                {{5{24'h000042}}, 24'd3}, {{5{24'h000001}}, 24'd5},
                {120'h0, 24'hFFFFFE}, 2'b10, 3, 2, 1};

    #2 rst = 1'b1;
    #1;
    check("reset stall", stall, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset alu_valid", alu_valid, 1'b0);
    check("reset result_valid", result_valid, 1'b0);
    check("reset result", result, '0);
    check("reset flags", flags_out, 2'b00);
    check("reset alu_a", alu_a, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;

    for (int i = 0; i < 5; i++) run_op(vecs[i], 0, 0, 0, 0);

    // en dropped for three cycles while lane 2 is on the ALU
    run_op(vecs[1], 4, 3, 3, 3);
    // en dropped in DONE: the pulse waits for en
    run_op(vecs[0], 3, 2, 2, 0);

    // reset while lane 3 is on the ALU
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start    = (c == 1);
      en       = 1'b1;
      mode_sel = 1'b1;
      alu_control = 4'd0;
      src_a    = vecs[1].a;
      src_b    = vecs[1].b;
    end
    #1;
    check("midop lane3_a", alu_a, 24'd4);
    rst = 1'b1;
    #1;
    check("midop stall", stall, 1'b0);
    check("midop busy", busy, 1'b0);
    check("midop result", result, '0);
    check("midop alu_valid", alu_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (result_valid || busy) pulses++;
    end
    check("midop no_activity_after", pulses, 0);

    // start held through DONE and one cycle beyond
    pulses = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start       = (c <= 4);
      en          = 1'b1;
      mode_sel    = 1'b0;
      alu_control = 4'd0;
      src_a       = vecs[0].a;
      src_b       = vecs[0].b;
      #1;
      if (result_valid) pulses++;
      if (c == 3) begin
        check("hold done_pulse", result_valid, 1'b1);
        check("hold done_stall", stall, 1'b0);
        check("hold done_busy", busy, 1'b1);
      end
      if (c == 4) begin
        check("hold reaccept_stall", stall, 1'b1);
        check("hold reaccept_busy", busy, 1'b0);
      end
      if (c == 6) check("hold second_pulse", result_valid, 1'b1);
      if (c == 8) check("hold final_idle", busy, 1'b0);
    end
    check("hold pulse_count", pulses, 2);
    check("hold result", result, vecs[0].res);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
